lmsm_sequencer: RTL and testbench

Parametrised load-multiple / store-multiple sequencer that moves a bitmask-selected set of register-file entries to or from consecutive memory words. The main controller FSM hands off an LM/SM instruction with a single `start` pulse and waits on `done`. It replaces the fixed 8-iteration counter loop with a mask scan that skips unselected registers. It adds a memory ready handshake so multi-cycle memories can be used.

---
 rtl/lmsm_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: scans a register mask and moves the
// selected registers to/from consecutive memory words. Optional macro: LMSM_TIMEOUT_EN.
module lmsm_sequencer #(
  parameter int unsigned NREG    = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_mask,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [IDX_W-1:0]  rf_idx,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_wen,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ACCESS,
    S_WB,
    S_DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [NREG-1:0]  mask;
  logic             store_q;
  logic [IDX_W-1:0] low_idx;

  if ((NREG < 2) || ((NREG & (NREG - 1)) != 0) || (TIMEOUT == 0)) begin : g_bad_param
    $error("lmsm_sequencer: NREG must be a power of 2 >= 2 and TIMEOUT nonzero");
  end

  assign mem_wdata = rf_rdata;

  // Lowest set bit of the remaining mask.
  always_comb begin
    low_idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef LMSM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             abort;

  // Wait counter restarts every time ACCESS is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != S_ACCESS) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
`ifdef LMSM_TIMEOUT_EN
    abort = 1'b0;
`endif
    case (state)
      S_IDLE:   if (start) next_state = S_SCAN;
      S_SCAN:   next_state = (mask == '0) ? S_DONE : S_ACCESS;
      S_ACCESS: begin
        if (mem_ready) begin
          next_state = store_q ? S_SCAN : S_WB;
        end
`ifdef LMSM_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          next_state = S_DONE;
          abort      = 1'b1;
        end
`endif
      end
      S_WB:     next_state = S_SCAN;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: mask, address, register index, load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '0;
      store_q  <= 1'b0;
      mem_addr <= '0;
      rf_idx   <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask     <= reg_mask;
            mem_addr <= base_addr;
            store_q  <= is_store;
          end
        end
        S_SCAN: begin
          if (mask != '0) rf_idx <= low_idx;
        end
        S_ACCESS: begin
          if (mem_ready) begin
            if (store_q) begin
              mask[rf_idx] <= 1'b0;
              mem_addr     <= mem_addr + ADDR_W'(1);
            end else begin
              rf_wdata <= mem_rdata;
            end
          end
`ifdef LMSM_TIMEOUT_EN
          else if (abort) begin
            mask <= '0;
          end
`endif
        end
        S_WB: begin
          mask[rf_idx] <= 1'b0;
          mem_addr     <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status and strobes are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      rf_wen  <= 1'b0;
    end else begin
      busy    <= (next_state != S_IDLE);
      done    <= (next_state == S_DONE);
      mem_req <= (next_state == S_ACCESS);
      mem_we  <= (next_state == S_ACCESS) && store_q;
      rf_wen  <= (next_state == S_WB);
    end
  end

`ifdef LMSM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= abort;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: directed LM/SM transfers with a
// stallable memory model and a negedge monitor that checks DUT events in order.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  reg_mask = '0;
  logic        busy, done, err, mem_req, mem_we, mem_ready, rf_wen;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata;
  logic [2:0]  rf_idx;

  logic [15:0] rf_model [8];
  int          cyc = 0;
  int          t0 = 0;
  int          stall = 0;
  logic        hold_low = 1'b0;
  int          wait_tb = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          reqcnt = 0;
  int          wencnt = 0;
  int          addr_jump = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;

  typedef struct {
    int          kind;   // 0 memory access, 1 RF write, 2 done
    logic        we;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic [15:0] data;
    int          cyc;
    logic        err;
  } ev_t;
  ev_t q[$];

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_idx(rf_idx), .rf_rdata(rf_rdata), .rf_wen(rf_wen), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: ready after 'stall' low cycles of a request; data only valid on ready.
  always @(posedge clk) begin
    if (mem_req && !mem_ready) wait_tb <= wait_tb + 1;
    else                       wait_tb <= 0;
  end
  assign mem_ready = !hold_low && (wait_tb >= stall);
  assign mem_rdata = mem_ready ? ~mem_addr : 16'hDEAD;
  assign rf_rdata  = rf_model[rf_idx];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL unexpected %s event: got one expected none (cycle %0d)", nm, cyc - t0);
  endtask

  function automatic void push(input int k, input logic we, input logic [15:0] a,
                               input logic [2:0] i, input logic [15:0] d,
                               input int c, input logic e);
    ev_t ev;
    ev.kind = k; ev.we = we; ev.addr = a; ev.idx = i; ev.data = d; ev.cyc = c; ev.err = e;
    q.push_back(ev);
  endfunction

  // Monitor: pops the next expected event whenever the DUT presents one.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (mem_req) reqcnt++;
      if (mem_req && prev_req && mem_addr != prev_addr) addr_jump++;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (rf_wen) wencnt++;
      if (mem_req && mem_ready) begin
        if (q.size() == 0) unexpected("mem_access");
        else begin
          e = q.pop_front();
          chk("mem_kind", 32'(e.kind == 0), 32'(1));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_idx", 32'(rf_idx), 32'(e.idx));
          if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (rf_wen) begin
        if (q.size() == 0) unexpected("rf_wen");
        else begin
          e = q.pop_front();
          chk("rf_kind", 32'(e.kind == 1), 32'(1));
          chk("rf_idx", 32'(rf_idx), 32'(e.idx));
          chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
        end
      end
      if (done) begin
        if (q.size() == 0) unexpected("done");
        else begin
          e = q.pop_front();
          chk("done_kind", 32'(e.kind == 2), 32'(1));
          chk("done_cycle", 32'(cyc - t0), 32'(e.cyc));
          chk("done_err", 32'(err), 32'(e.err));
        end
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic go(input logic st, input logic [15:0] base, input logic [7:0] m);
    @(negedge clk);
    reqcnt = 0; wencnt = 0; addr_jump = 0;
    start = 1'b1; is_store = st; base_addr = base; reg_mask = m;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: got no done expected done within 200 cycles");
    end
    @(negedge clk);
  endtask

  logic [15:0] ld_addr [8] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                               16'h0002, 16'h0003, 16'h0004, 16'h0005};
  logic [15:0] ld_data [8] = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE,
                               16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf_model[i] = 16'hA0A0 + 16'(i);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rf_wen", 32'(rf_wen), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rf_idx", 32'(rf_idx), 0);
    chk("rst_rf_wdata", 32'(rf_wdata), 0);
    reset = 1'b0;

    // Store, sparse mask.
    push(0, 1'b1, 16'h0040, 3'd0, 16'hA0A0, 0, 1'b0);
    push(0, 1'b1, 16'h0041, 3'd5, 16'hA0A5, 0, 1'b0);
    push(0, 1'b1, 16'h0042, 3'd7, 16'hA0A7, 0, 1'b0);
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 8, 1'b0);
    go(1'b1, 16'h0040, 8'hA1);
    chk("store_busy", 32'(busy), 1);
    wait_done();
    chk("store_q_empty", 32'(q.size()), 0);
    chk("store_reqcnt", 32'(reqcnt), 3);

    // Load, full mask, address wrap.
    for (int i = 0; i < 8; i++) begin
      push(0, 1'b0, ld_addr[i], 3'(i), 16'h0, 0, 1'b0);
      push(1, 1'b0, 16'h0, 3'(i), ld_data[i], 0, 1'b0);
    end
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 26, 1'b0);
    go(1'b0, 16'hFFFE, 8'hFF);
    wait_done();
    chk("load_q_empty", 32'(q.size()), 0);
    chk("load_wencnt", 32'(wencnt), 8);

    // Empty mask.
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 2, 1'b0);
    go(1'b0, 16'h1234, 8'h00);
    wait_done();
    chk("empty_reqcnt", 32'(reqcnt), 0);
    chk("empty_wencnt", 32'(wencnt), 0);
    chk("empty_q_empty", 32'(q.size()), 0);

    // Load with three wait cycles.
    stall = 3;
    push(0, 1'b0, 16'h0100, 3'd2, 16'h0, 0, 1'b0);
    push(1, 1'b0, 16'h0, 3'd2, 16'hFEFF, 0, 1'b0);
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 8, 1'b0);
    go(1'b0, 16'h0100, 8'h04);
    wait_done();
    stall = 0;
    chk("stall_reqcnt", 32'(reqcnt), 4);
    chk("stall_addr_stable", 32'(addr_jump), 0);
    chk("stall_q_empty", 32'(q.size()), 0);

    // Reset during second access; start pulsed while busy.
    push(0, 1'b1, 16'h0010, 3'd0, 16'hA0A0, 0, 1'b0);
    go(1'b1, 16'h0010, 8'h03);
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; reg_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0; hold_low = 1'b1;
    @(negedge clk);
    chk("rst2_mem_req", 32'(mem_req), 1);
    chk("rst2_mem_addr", 32'(mem_addr), 32'h11);
    chk("rst2_rf_idx", 32'(rf_idx), 1);
    reset = 1'b1;
    #1;
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_req_clr", 32'(mem_req), 0);
    chk("rst2_we_clr", 32'(mem_we), 0);
    chk("rst2_addr_clr", 32'(mem_addr), 0);
    chk("rst2_idx_clr", 32'(rf_idx), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; hold_low = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst2_idle_busy", 32'(busy), 0);
    end
    chk("rst2_q_empty", 32'(q.size()), 0);

    // Start coincident with done is ignored, accepted a cycle later.
    push(0, 1'b1, 16'h0020, 3'd0, 16'hA0A0, 0, 1'b0);
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 4, 1'b0);
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 7, 1'b0);
    go(1'b1, 16'h0020, 8'h01);
    repeat (2) @(negedge clk);
    start = 1'b1; is_store = 1'b0; reg_mask = 8'h00;
    @(negedge clk);
    chk("coinc_done", 32'(done), 1);
    @(negedge clk);
    chk("coinc_idle", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    chk("coinc_accept", 32'(busy), 1);
    wait_done();
    chk("coinc_q_empty", 32'(q.size()), 0);

`ifdef LMSM_TIMEOUT_EN
    // Ready never arrives: abort after TIMEOUT cycles.
    hold_low = 1'b1;
    push(2, 1'b0, 16'h0, 3'd0, 16'h0, 17, 1'b1);
    go(1'b0, 16'h0050, 8'h06);
    wait_done();
    hold_low = 1'b0;
    chk("to_reqcnt", 32'(reqcnt), 15);
    chk("to_wencnt", 32'(wencnt), 0);
    chk("to_idle", 32'(busy), 0);
    chk("to_q_empty", 32'(q.size()), 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
